// File: rtl/debug_pkg.sv
// Shared definitions for the debug display path: select-code width, the
// select-code enum decoded by the seven-segment mux, and the select update rule.
package debug_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_INSTR      = 4'd0,
        SEL_RD1        = 4'd1,
        SEL_RD2        = 4'd2,
        SEL_IMMEXT     = 4'd3,
        SEL_ALU_SRC    = 4'd4,
        SEL_ALU_OUT    = 4'd5,
        SEL_DMEM_OUT   = 4'd6,
        SEL_PCPLUS4    = 4'd7,
        SEL_RESULT     = 4'd8,
        SEL_RD2_OUT    = 4'd9,
        SEL_RESULT_OUT = 4'd10,
        SEL_WDMUX_OUT  = 4'd11,
        SEL_PCNEXT     = 4'd12,
        SEL_PC         = 4'd13,
        SEL_PCTARGET   = 4'd14,
        SEL_CONTROL    = 4'd15
    } sel_e;

    // Up/down step through the select codes with natural 4-bit wrap; opposing
    // requests in the same cycle cancel.
    function automatic sel_e sel_update(input sel_e cur, input logic up, input logic down);
        logic [SEL_W-1:0] code;
        code = cur;
        case ({up, down})
            2'b10:   code = code + SEL_W'(1);
            2'b01:   code = code - SEL_W'(1);
            default: code = code;
        endcase
        return sel_e'(code);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-flop synchronizer, stability counter, accepted level and
// a one-cycle press pulse on each accepted release->press transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal gets a default before the conditional logic so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d      = key_n;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        stable_dly_d = stable_q;
        press_d      = stable_dly_q & ~stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/debug_input_ctrl.sv
// Debug input controller: debounced select keys drive the display-select code;
// run switch and step key produce the core clock-enable and an executed-cycle count.
module debug_input_ctrl
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_next_n,
    input  logic             key_prev_n,
    input  logic             key_step_n,
    input  logic             sw_run,
    output logic [SEL_W-1:0] selm,
    output logic             cpu_en,
    output logic [31:0]      step_count
);

    logic next_press, prev_press, step_press;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .reset (reset),
        .key_n (key_next_n),
        .press (next_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .reset (reset),
        .key_n (key_prev_n),
        .press (prev_press)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .reset (reset),
        .key_n (key_step_n),
        .press (step_press)
    );

    sel_e        selm_q, selm_d;
    logic        run_meta_q, run_meta_d;
    logic        run_sync_q, run_sync_d;
    logic        cpu_en_q, cpu_en_d;
    logic [31:0] step_count_q, step_count_d;

    // Step presses during free-run are dropped rather than remembered.
    always_comb begin
        selm_d       = sel_update(selm_q, next_press, prev_press);
        run_meta_d   = sw_run;
        run_sync_d   = run_meta_q;
        cpu_en_d     = run_sync_q | (step_press & ~run_sync_q);
        step_count_d = step_count_q;
        if (cpu_en_q) begin
            step_count_d = step_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            selm_q       <= SEL_INSTR;
            run_meta_q   <= 1'b0;
            run_sync_q   <= 1'b0;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            selm_q       <= selm_d;
            run_meta_q   <= run_meta_d;
            run_sync_q   <= run_sync_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign selm       = selm_q;
    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;

endmodule
